// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the load/store path: load/store size encodings as
//   produced by the decoder, the LSU controller state type, data-bus widths
//   and small helpers that classify an access by its size and low address
//   bits.
// ----------------------------------------------------------------------------
package riscv_pkg;

    // Data-bus geometry
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    // Load/store size encodings (bit 2 set = zero-extending load)
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // True for the five encodings the LSU can put on the bus.
    function automatic logic size_supported(input logic [2:0] size);
        logic ok;
        case (size)
            LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfword on an odd byte, or word off a word boundary.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        return ((size[1:0] == 2'd1) && addr_lo[0]) ||
               ((size[1:0] == 2'd2) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
//   Combinational load-data aligner. Selects the addressed byte or halfword
//   from a bus word and sign- or zero-extends it to 32 bits.
//
//   Ports:
//     rdata_i    in   raw read data from the bus
//     size_i     in   load size (LDST_B/H/W/BU/HU)
//     addr_lo_i  in   address bits [1:0] of the access
//     data_o     out  aligned, extended load data (0 for unsupported sizes)
// ----------------------------------------------------------------------------
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [BUS_DATA_W-1:0] rdata_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            addr_lo_i,
    output logic [BUS_DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Only addr[1] picks the half; an odd halfword address is treated as
        // the containing aligned half.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = '0;
        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'h0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'h0, half_sel};
            LDST_W:  data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_riscv.sv
// ----------------------------------------------------------------------------
// lsu_riscv
//   Load/store unit controller. Turns a decoder memory request into a single
//   request/grant(/response) transaction on the data bus, stalls the core
//   until the access completes, generates byte enables and replicated store
//   data, and registers aligned/extended load data for writeback.
//
//   Build option: LSU_MISALIGN_EXC_EN
//     defined   - misaligned H/HU/W accesses skip the bus and pulse
//                 lsu_misalign_o for the one DONE cycle.
//     undefined - lsu_misalign_o is tied low; misaligned halfwords use
//                 addr[1] only and misaligned words hit the containing word.
//
//   Ports:
//     clk_i, arstn_i     clock, asynchronous active-low reset
//     lsu_req_i          access request (held while stalled)
//     lsu_we_i           1 = store, 0 = load
//     lsu_size_i         LDST_* size encoding
//     lsu_addr_i         effective byte address
//     lsu_data_i         store data
//     lsu_data_o         last completed load result
//     lsu_stall_req_o    stall the core (combinational)
//     lsu_misalign_o     misaligned-access flag
//     data_req_o/we_o/be_o/addr_o/wdata_o   bus request side
//     data_gnt_i, data_rvalid_i, data_rdata_i bus grant / response side
// ----------------------------------------------------------------------------
module lsu_riscv
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_size_i,
    input  logic [ADDR_W-1:0]     lsu_addr_i,
    input  logic [BUS_DATA_W-1:0] lsu_data_i,
    output logic [BUS_DATA_W-1:0] lsu_data_o,
    output logic                  lsu_stall_req_o,
    output logic                  lsu_misalign_o,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [BUS_BE_W-1:0]   data_be_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [BUS_DATA_W-1:0] data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [BUS_DATA_W-1:0] data_rdata_i
);

    lsu_state_t            state_q;
    logic                  data_req_q;
    logic [BUS_DATA_W-1:0] lsu_data_q;
    logic [2:0]            size_q;
    logic [1:0]            addr_lo_q;
    logic                  misalign_d;
    logic [BUS_DATA_W-1:0] load_data_d;

`ifdef LSU_MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign_d     = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    assign lsu_misalign_o = misalign_q;
`else
    assign misalign_d     = 1'b0;
    assign lsu_misalign_o = 1'b0;
`endif

    // Size and offset are captured when the access starts so extraction does
    // not depend on the core still presenting them when the response lands.
    lsu_load_align u_load_align (
        .rdata_i   (data_rdata_i),
        .size_i    (size_q),
        .addr_lo_i (addr_lo_q),
        .data_o    (load_data_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= IDLE;
            data_req_q <= 1'b0;
            lsu_data_q <= '0;
            size_q     <= LDST_B;
            addr_lo_q  <= 2'b00;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef LSU_MISALIGN_EXC_EN
            // Pulse: only ever set on the IDLE->DONE edge below.
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        size_q    <= lsu_size_i;
                        addr_lo_q <= lsu_addr_i[1:0];
                        if (!size_supported(lsu_size_i)) begin
                            state_q    <= DONE;
                            lsu_data_q <= '0;
                        end else if (misalign_d) begin
                            state_q    <= DONE;
`ifdef LSU_MISALIGN_EXC_EN
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            state_q    <= REQ;
                            data_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        data_req_q <= 1'b0;
                        state_q    <= lsu_we_i ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        lsu_data_q <= load_data_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // One-cycle release of the stall; a still-high request
                    // starts a fresh access from IDLE.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_stall_req_o = lsu_req_i & (state_q != DONE);
    assign lsu_data_o      = lsu_data_q;
    assign data_req_o      = data_req_q;
    assign data_we_o       = lsu_we_i;
    assign data_addr_o     = {lsu_addr_i[ADDR_W-1:2], 2'b00};

    // Byte lanes and store-data replication follow the live request; the
    // core holds it stable for the whole access.
    always_comb begin
        data_be_o = '0;
        case (lsu_size_i)
            LDST_B, LDST_BU: data_be_o = 4'b0001 << lsu_addr_i[1:0];
            LDST_H, LDST_HU: data_be_o = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            LDST_W:          data_be_o = 4'b1111;
            default:         data_be_o = '0;
        endcase
    end

    always_comb begin
        data_wdata_o = lsu_data_i;
        case (lsu_size_i[1:0])
            2'd0:    data_wdata_o = {4{lsu_data_i[7:0]}};
            2'd1:    data_wdata_o = {2{lsu_data_i[15:0]}};
            default: data_wdata_o = lsu_data_i;
        endcase
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// ----------------------------------------------------------------------------
// tb_lsu_riscv
//   Scoreboard bench for lsu_riscv. Each issued access is run through a
//   behavioural model that derives byte lanes, replicated store data and
//   extended load data with plain arithmetic; expected bus requests and
//   completions are queued and a negedge monitor pops and compares them
//   whenever the DUT presents a granted request or a completion cycle.
//   Model follows LSU_MISALIGN_EXC_EN the same way the RTL build does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_riscv;
    import riscv_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              arstn_i = 1'b0;
    logic              lsu_req_i = 1'b0;
    logic              lsu_we_i = 1'b0;
    logic [2:0]        lsu_size_i = 3'd0;
    logic [ADDR_W-1:0] lsu_addr_i = '0;
    logic [31:0]       lsu_data_i = '0;
    logic [31:0]       lsu_data_o;
    logic              lsu_stall_req_o;
    logic              lsu_misalign_o;
    logic              data_req_o;
    logic              data_we_o;
    logic [3:0]        data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [31:0]       data_wdata_o;
    logic              data_gnt_i = 1'b0;
    logic              data_rvalid_i = 1'b0;
    logic [31:0]       data_rdata_i = '0;

    lsu_riscv #(.ADDR_W(ADDR_W)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        misalign;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    logic [31:0] mdl_data = '0;   // model of the writeback register

    // Behavioural model of one access.
    task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd,
                         output bit bus, output bus_exp_t b, output done_exp_t d, output int stalls);
        int          nbytes, off;
        logic [31:0] mask, val;
        bit          sgn, mis;
        bus    = 0;
        b      = '{default: '0};
        d      = '{default: '0};
        stalls = 1;
        if (size == 3'd3 || size > 3'd5) begin
            mdl_data = '0;
            d.data   = '0;
        end else begin
            nbytes = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
            sgn    = (size < 3'd4) && (nbytes < 4);
            mis    = (addr % nbytes) != 0;
`ifdef LSU_MISALIGN_EXC_EN
            if (mis) begin
                d.data     = mdl_data;
                d.misalign = 1'b1;
            end else
`endif
            begin
                off    = (nbytes == 1) ? int'(addr % 4) : (nbytes == 2) ? int'((addr % 4) / 2 * 2) : 0;
                mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
                b.we   = we;
                b.be   = 4'(((1 << nbytes) - 1) << off);
                b.addr = addr - (addr % 4);
                for (int i = 0; i < 4 / nbytes; i++)
                    b.wdata = b.wdata | ((wd & mask) << (8 * nbytes * i));
                if (!we) begin
                    val = (rd >> (8 * off)) & mask;
                    if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
                    mdl_data = val;
                end
                d.data = mdl_data;
                bus    = 1;
                stalls = we ? 2 + gd : 2 + gd + rvd;
            end
        end
    endtask

    // Issue one access and play the bus slave: grant after gd waiting
    // cycles, respond rvd cycles after the grant.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rvd, input logic [31:0] rd);
        bit        bus, granted, done;
        bus_exp_t  b;
        done_exp_t d;
        int        exp_stall, stalls, waited, since;
        model(we, size, addr, wd, rd, gd, rvd, bus, b, d, exp_stall);
        if (bus) bus_q.push_back(b);
        done_q.push_back(d);
        granted = 0; done = 0; stalls = 0; waited = 0; since = 0;
        @(posedge clk_i); #1;
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (!lsu_stall_req_o) begin
                done = 1;
            end else begin
                stalls++;
                data_gnt_i    = 1'b0;
                data_rvalid_i = 1'b0;
                data_rdata_i  = $urandom();
                if (granted && !we) begin
                    since++;
                    if (since == rvd) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = rd;
                    end
                end
                if (data_req_o && !granted) begin
                    if (waited == gd) begin
                        data_gnt_i = 1'b1;
                        granted    = 1;
                    end else begin
                        waited++;
                    end
                end
                @(posedge clk_i); #1;
            end
        end
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        check("access_timeout", {31'b0, done}, 32'd1);
        check("stall_cycles", stalls, exp_stall);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        check("misalign_after_done", {31'b0, lsu_misalign_o}, 32'd0);
    endtask

    // Monitor / scoreboard
    bit        hold_req = 0;
    logic [31:0] hold_addr = '0;
    bus_exp_t  mon_b;
    done_exp_t mon_d;

    always @(negedge clk_i) begin
        if (!arstn_i) begin
            hold_req = 0;
        end else begin
            if (hold_req) begin
                check("req_held", {31'b0, data_req_o}, 32'd1);
                check("addr_held", data_addr_o, hold_addr);
            end
            hold_req  = data_req_o && !data_gnt_i;
            hold_addr = data_addr_o;
            if (data_req_o && data_gnt_i) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", {31'b0, data_req_o}, 32'd0);
                end else begin
                    mon_b = bus_q.pop_front();
                    check("bus_we", {31'b0, data_we_o}, {31'b0, mon_b.we});
                    check("bus_be", {28'b0, data_be_o}, {28'b0, mon_b.be});
                    check("bus_addr", data_addr_o, mon_b.addr);
                    if (mon_b.we) check("bus_wdata", data_wdata_o, mon_b.wdata);
                end
            end
            if (lsu_req_i && !lsu_stall_req_o) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {31'b0, lsu_stall_req_o}, 32'd1);
                end else begin
                    mon_d = done_q.pop_front();
                    check("load_data", lsu_data_o, mon_d.data);
                    check("misalign", {31'b0, lsu_misalign_o}, {31'b0, mon_d.misalign});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_lsu_data", lsu_data_o, 32'h0);
        check("rst_data_req", {31'b0, data_req_o}, 32'd0);
        check("rst_misalign", {31'b0, lsu_misalign_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 arstn_i = 1'b1;

        // Directed accesses
        access(1'b0, LDST_W, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        check("lw_result", lsu_data_o, 32'hDEADBEEF);
        access(1'b0, LDST_B, 32'h103, 32'h0, 0, 1, 32'h80123456);
        check("lb_result", lsu_data_o, 32'hFFFFFF80);
        access(1'b0, LDST_BU, 32'h103, 32'h0, 1, 2, 32'h80123456);
        check("lbu_result", lsu_data_o, 32'h00000080);
        access(1'b1, LDST_H, 32'h202, 32'h1234ABCD, 0, 1, 32'h0);
        check("sh_keeps_load_data", lsu_data_o, 32'h00000080);
        access(1'b0, LDST_W, 32'h404, 32'h0, 3, 1, 32'h13579BDF);
        access(1'b0, LDST_H, 32'h102, 32'h0, 0, 1, 32'h80017FFF);
        check("lh_result", lsu_data_o, 32'hFFFF8001);
        access(1'b0, LDST_HU, 32'h100, 32'h0, 2, 3, 32'h80017FFF);
        check("lhu_result", lsu_data_o, 32'h00007FFF);
        access(1'b0, LDST_W, 32'h101, 32'h0, 0, 1, 32'hCAFEF00D);
        access(1'b0, 3'd3, 32'h500, 32'h0, 0, 1, 32'h0);
        check("unsupported_clears", lsu_data_o, 32'h0);
        access(1'b0, LDST_W, 32'h600, 32'h0, 0, 1, 32'h2468ACE0);

        // Reset while waiting for a read response
        bus_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h0});
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h300;
        @(posedge clk_i); #1;
        check("rst_test_req", {31'b0, data_req_o}, 32'd1);
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        #1 arstn_i = 1'b0;
        lsu_req_i = 1'b0;
        mdl_data  = '0;
        #1;
        check("midrst_lsu_data", lsu_data_o, 32'h0);
        check("midrst_data_req", {31'b0, data_req_o}, 32'd0);
        check("midrst_misalign", {31'b0, lsu_misalign_o}, 32'd0);
        @(posedge clk_i); #1 arstn_i = 1'b1;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hBADC0DE5;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0;
        check("stale_rvalid_ignored", lsu_data_o, mdl_data);
        check("stale_no_req", {31'b0, data_req_o}, 32'd0);
        // Next access must start cleanly from IDLE
        access(1'b0, LDST_B, 32'h701, 32'h0, 0, 1, 32'h0000AB00);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom());
        end

        repeat (2) @(posedge clk_i);
        #1;
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
